// File: rtl/riscv_mem_pkg.sv
`default_nettype none
// ---- riscv_mem_pkg: funct3 codes, controller states, access legality check. Rev 1.0 ----
package riscv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } mem_state_e;

  // High for misaligned halves/words and for any funct3 that has no meaning for the direction.
  function automatic logic access_err(input logic we, input logic [2:0] funct3,
                                      input logic [1:0] lane);
    logic err;
    err = 1'b0;
    case (funct3)
      F3_B:    err = 1'b0;
      F3_H:    err = lane[0];
      F3_W:    err = (lane != 2'b00);
      F3_BU:   err = we;
      F3_HU:   err = we | lane[0];
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ---- mem_lane_align: load extract/extend and store byte-enable/replication. Rev 1.0 ----
module mem_lane_align
  import riscv_mem_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] rword_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [3:0]  be_o,
  output logic [31:0] wword_o
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte    = rword_i[{lane_i, 3'b000} +: 8];
    sel_half    = lane_i[1] ? rword_i[31:16] : rword_i[15:0];
    load_data_o = 32'd0;
    case (funct3_i)
      F3_B:    load_data_o = {{24{sel_byte[7]}}, sel_byte};
      F3_H:    load_data_o = {{16{sel_half[15]}}, sel_half};
      F3_W:    load_data_o = rword_i;
      F3_BU:   load_data_o = {24'd0, sel_byte};
      F3_HU:   load_data_o = {16'd0, sel_half};
      default: load_data_o = 32'd0;
    endcase
  end

  // Store data is replicated across lanes so the byte enables alone pick the target bytes.
  always_comb begin
    be_o    = 4'b0000;
    wword_o = 32'd0;
    case (funct3_i)
      F3_B: begin
        be_o    = 4'b0001 << lane_i;
        wword_o = {4{wdata_i[7:0]}};
      end
      F3_H: begin
        be_o    = lane_i[1] ? 4'b1100 : 4'b0011;
        wword_o = {2{wdata_i[15:0]}};
      end
      F3_W: begin
        be_o    = 4'b1111;
        wword_o = wdata_i;
      end
      default: begin
        be_o    = 4'b0000;
        wword_o = 32'd0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ---- data_mem_ctrl: word RAM with req/ack handshake, wait states, RV32 byte/half/word access. ----
// ---- Rev 1.0. Optional DATA_MEM_STATS_EN adds load/store/error counters.                      ----
module data_mem_ctrl
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              req,
  input  logic              we,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              ack,
  output logic [31:0]       rdata,
  output logic              misaligned
`ifdef DATA_MEM_STATS_EN
  ,
  output logic [31:0]       load_cnt,
  output logic [31:0]       store_cnt,
  output logic [31:0]       err_cnt
`endif
);

  localparam int         IDX_W   = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_M1 = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  mem_state_e       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             we_q;
  logic [2:0]       f3_q;
  logic [IDX_W-1:0] idx_q;
  logic [1:0]       lane_q;
  logic [31:0]      wdata_q;
  logic             err_q;

  logic [31:0]      mem_q [DEPTH_WORDS];

  logic             w_acc_we;
  logic [2:0]       w_acc_f3;
  logic [IDX_W-1:0] w_acc_idx;
  logic [1:0]       w_acc_lane;
  logic [31:0]      w_acc_wdata;
  logic             w_acc_err;
  logic [31:0]      w_load;
  logic [3:0]       w_be;
  logic [31:0]      w_wword;
  logic             w_commit;

  generate
    if (ADDR_W > IDX_W + 2) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^addr[ADDR_W-1:IDX_W+2];
    end
  endgenerate

  // In IDLE the live inputs describe the access (needed when RESP follows IDLE directly).
  always_comb begin
    w_acc_we    = we_q;
    w_acc_f3    = f3_q;
    w_acc_idx   = idx_q;
    w_acc_lane  = lane_q;
    w_acc_wdata = wdata_q;
    w_acc_err   = err_q;
    if (state_q == ST_IDLE) begin
      w_acc_we    = we;
      w_acc_f3    = funct3;
      w_acc_idx   = addr[IDX_W+1:2];
      w_acc_lane  = addr[1:0];
      w_acc_wdata = wdata;
      w_acc_err   = access_err(we, funct3, addr[1:0]);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_M1;
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      idx_q   <= '0;
      lane_q  <= 2'd0;
      wdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == ST_IDLE && req) begin
        we_q    <= we;
        f3_q    <= funct3;
        idx_q   <= addr[IDX_W+1:2];
        lane_q  <= addr[1:0];
        wdata_q <= wdata;
        err_q   <= w_acc_err;
      end
    end
  end

  mem_lane_align u_align (
    .funct3_i    (w_acc_f3),
    .lane_i      (w_acc_lane),
    .rword_i     (mem_q[w_acc_idx]),
    .wdata_i     (w_acc_wdata),
    .load_data_o (w_load),
    .be_o        (w_be),
    .wword_o     (w_wword)
  );

  // A reset asserted before the RESP-entry edge suppresses the commit.
  assign w_commit = Reset && (state_d == ST_RESP) && w_acc_we && !w_acc_err;

  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          mem_q[w_acc_idx][8*b +: 8] <= w_wword[8*b +: 8];
        end
      end
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign ack        = (state_q == ST_RESP);
  assign rdata      = (ack && !we_q && !err_q) ? w_load : 32'd0;
  assign misaligned = ack && err_q;

`ifdef DATA_MEM_STATS_EN
  always_ff @(posedge clk) begin
    if (!Reset) begin
      load_cnt  <= 32'd0;
      store_cnt <= 32'd0;
      err_cnt   <= 32'd0;
    end else if (ack) begin
      if (err_q) begin
        err_cnt <= err_cnt + 32'd1;
      end else if (we_q) begin
        store_cnt <= store_cnt + 32'd1;
      end else begin
        load_cnt <= load_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
// ---- tb_data_mem_ctrl: table vectors, corner sequences and random traffic vs. a byte-array model. ----
module tb_data_mem_ctrl;

  localparam int NDUT = 3;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n   [NDUT];
  logic        req_s   [NDUT];
  logic        we_s    [NDUT];
  logic [2:0]  f3_s    [NDUT];
  logic [31:0] addr_s  [NDUT];
  logic [31:0] wdata_s [NDUT];
  logic        busy_s  [NDUT];
  logic        ack_s   [NDUT];
  logic [31:0] rdata_s [NDUT];
  logic        mis_s   [NDUT];

  generate
    for (genvar g = 0; g < NDUT; g++) begin : g_dut
      localparam int WS = (g == 0) ? 0 : (g == 1) ? 2 : 3;
      data_mem_ctrl #(.ADDR_W(32), .DEPTH_WORDS(256), .WAIT_STATES(WS)) u_dut (
        .clk        (clk),
        .Reset      (rst_n[g]),
        .req        (req_s[g]),
        .we         (we_s[g]),
        .funct3     (f3_s[g]),
        .addr       (addr_s[g]),
        .wdata      (wdata_s[g]),
        .busy       (busy_s[g]),
        .ack        (ack_s[g]),
        .rdata      (rdata_s[g]),
        .misaligned (mis_s[g])
      );
    end
  endgenerate

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] mem_m [NDUT][1024];

  function automatic int ws_of(input int k);
    return (k == 0) ? 0 : (k == 1) ? 2 : 3;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: RAM as a flat little-endian byte array of 1024 bytes.
  task automatic model_access(input int k, input logic w, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd,
                              output logic [31:0] rd, output logic mis);
    int size;
    bit sgn;
    bit legal;
    int base;
    logic [31:0] v;
    rd = 32'd0; mis = 1'b0; size = 1; sgn = 1'b0; legal = 1'b1;
    case (f3)
      3'd0: begin size = 1; sgn = 1'b1; end
      3'd1: begin size = 2; sgn = 1'b1; end
      3'd2: begin size = 4; end
      3'd4: begin size = 1; legal = !w; end
      3'd5: begin size = 2; legal = !w; end
      default: legal = 1'b0;
    endcase
    if (!legal || (a % size) != 0) begin
      mis = 1'b1;
      return;
    end
    base = int'(a % 1024);
    if (w) begin
      for (int i = 0; i < size; i++) mem_m[k][base+i] = wd[8*i +: 8];
    end else begin
      v = 32'd0;
      for (int i = 0; i < size; i++) v = v | (32'(mem_m[k][base+i]) << (8*i));
      if (sgn && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
      rd = v;
    end
  endtask

  task automatic dut_access(input int k, input logic w, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd,
                            output logic [31:0] rd, output logic mis,
                            output int lat, output int busy_n);
    bit found;
    @(negedge clk);
    req_s[k] = 1'b1; we_s[k] = w; f3_s[k] = f3; addr_s[k] = a; wdata_s[k] = wd;
    @(negedge clk);
    // Scramble the bus after capture: only the captured copy may matter now.
    req_s[k] = 1'b0; we_s[k] = 1'($urandom); f3_s[k] = 3'($urandom);
    addr_s[k] = $urandom; wdata_s[k] = $urandom;
    lat = -1; busy_n = 0; rd = 32'd0; mis = 1'b0; found = 1'b0;
    for (int c = 1; c <= 40 && !found; c++) begin
      if (busy_s[k]) busy_n++;
      if (ack_s[k]) begin
        lat = c; rd = rdata_s[k]; mis = mis_s[k]; found = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  task automatic run_one(input int k, input string name, input logic w, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] erd, ard;
    logic emis, amis;
    int lat, bn;
    model_access(k, w, f3, a, wd, erd, emis);
    dut_access(k, w, f3, a, wd, ard, amis, lat, bn);
    check({name, ".rdata"}, ard, erd);
    check({name, ".mis"}, 32'(amis), 32'(emis));
    check({name, ".lat"}, 32'(lat), 32'(ws_of(k) + 1));
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_mis;
  } vec_t;

  vec_t vt[$];

  initial begin
    logic [31:0] ard, mrd;
    logic amis, mmis;
    int lat, bn;
    bit saw_ack;

    for (int k = 0; k < NDUT; k++) begin
      rst_n[k] = 1'b0; req_s[k] = 1'b0; we_s[k] = 1'b0; f3_s[k] = 3'd0;
      addr_s[k] = 32'd0; wdata_s[k] = 32'd0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      check("rst.busy", 32'(busy_s[k]), 32'd0);
      check("rst.ack", 32'(ack_s[k]), 32'd0);
      check("rst.rdata", rdata_s[k], 32'd0);
      check("rst.mis", 32'(mis_s[k]), 32'd0);
      rst_n[k] = 1'b1;
    end

    // Give words 0..31 of every instance known contents.
    for (int k = 0; k < NDUT; k++)
      for (int w = 0; w < 32; w++)
        run_one(k, "init", 1'b1, 3'd2, 32'(w * 4), $urandom);

    vt.push_back('{1'b1, 3'b010, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0});
    vt.push_back('{1'b0, 3'b010, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0});
    vt.push_back('{1'b1, 3'b000, 32'h11,  32'h55,       32'h0,        1'b0});
    vt.push_back('{1'b0, 3'b010, 32'h10,  32'h0,        32'hDEAD55EF, 1'b0});
    vt.push_back('{1'b0, 3'b000, 32'h13,  32'h0,        32'hFFFFFFDE, 1'b0});
    vt.push_back('{1'b0, 3'b100, 32'h13,  32'h0,        32'h000000DE, 1'b0});
    vt.push_back('{1'b0, 3'b001, 32'h12,  32'h0,        32'hFFFFDEAD, 1'b0});
    vt.push_back('{1'b0, 3'b010, 32'h0E,  32'h0,        32'h0,        1'b1});
    vt.push_back('{1'b1, 3'b001, 32'h11,  32'h1234,     32'h0,        1'b1});
    vt.push_back('{1'b0, 3'b010, 32'h10,  32'h0,        32'hDEAD55EF, 1'b0});
    vt.push_back('{1'b0, 3'b101, 32'h10,  32'h0,        32'h000055EF, 1'b0});
    vt.push_back('{1'b0, 3'b000, 32'h10,  32'h0,        32'hFFFFFFEF, 1'b0});
    vt.push_back('{1'b0, 3'b011, 32'h10,  32'h0,        32'h0,        1'b1});
    vt.push_back('{1'b1, 3'b010, 32'h400, 32'hA5A5A5A5, 32'h0,        1'b0});
    vt.push_back('{1'b0, 3'b010, 32'h000, 32'h0,        32'hA5A5A5A5, 1'b0});
    vt.push_back('{1'b1, 3'b010, 32'h14,  32'h0,        32'h0,        1'b0});
    vt.push_back('{1'b1, 3'b100, 32'h14,  32'hFF,       32'h0,        1'b1});
    vt.push_back('{1'b1, 3'b001, 32'h16,  32'hBEEF,     32'h0,        1'b0});
    vt.push_back('{1'b0, 3'b010, 32'h14,  32'h0,        32'hBEEF0000, 1'b0});
    vt.push_back('{1'b0, 3'b001, 32'h16,  32'h0,        32'hFFFFBEEF, 1'b0});

    foreach (vt[i]) begin
      model_access(1, vt[i].we, vt[i].f3, vt[i].addr, vt[i].wdata, mrd, mmis);
      dut_access(1, vt[i].we, vt[i].f3, vt[i].addr, vt[i].wdata, ard, amis, lat, bn);
      check($sformatf("vec%0d.rdata", i), ard, vt[i].exp_rd);
      check($sformatf("vec%0d.mis", i), 32'(amis), 32'(vt[i].exp_mis));
      check($sformatf("vec%0d.lat", i), 32'(lat), 32'd3);
      check($sformatf("vec%0d.busy", i), 32'(bn), 32'd3);
    end

    // Store aborted by reset in the second WAIT cycle of the WAIT_STATES=3 instance.
    @(negedge clk);
    req_s[2] = 1'b1; we_s[2] = 1'b1; f3_s[2] = 3'b010; addr_s[2] = 32'h20; wdata_s[2] = 32'h12345678;
    @(negedge clk);
    req_s[2] = 1'b0;
    @(negedge clk);
    rst_n[2] = 1'b0;
    @(negedge clk);
    check("abort.busy", 32'(busy_s[2]), 32'd0);
    check("abort.ack", 32'(ack_s[2]), 32'd0);
    rst_n[2] = 1'b1;
    saw_ack = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (ack_s[2]) saw_ack = 1'b1;
    end
    check("abort.noack", 32'(saw_ack), 32'd0);
    run_one(2, "abort.word", 1'b0, 3'b010, 32'h20, 32'h0);

    // req held high: acks only every WAIT_STATES+2 cycles.
    model_access(1, 1'b0, 3'b010, 32'h10, 32'h0, mrd, mmis);
    @(negedge clk);
    req_s[1] = 1'b1; we_s[1] = 1'b0; f3_s[1] = 3'b010; addr_s[1] = 32'h10; wdata_s[1] = 32'h0;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      check($sformatf("hold.ack%0d", c), 32'(ack_s[1]), 32'((c % 4) == 3));
      if ((c % 4) == 3) check($sformatf("hold.rdata%0d", c), rdata_s[1], mrd);
    end
    req_s[1] = 1'b0;

    for (int k = 0; k < 2; k++) begin
      for (int n = 0; n < 150; n++) begin
        logic [31:0] a;
        a = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
        run_one(k, $sformatf("rnd%0d_%0d", k, n), 1'($urandom), 3'($urandom), a, $urandom);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Parametrised successor to the single-cycle core's data memory: a word-organised data RAM behind a req/ack handshake.
- Adds configurable depth and wait states, RV32 byte/half/word loads and stores selected by funct3, and misalignment detection.
- Sits between the CPU's load/store path and storage; lets the core move to a stalling/multi-cycle memory model.

Parameters:
- ADDR_W, 32, byte-address width of addr port.
- DEPTH_WORDS, 256, number of 32-bit words; power of two.
- WAIT_STATES, 0, extra cycles spent in WAIT before the response (0..15).

Ports:
- clk  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-low reset; sampled on rising clk edge.
- req  input  1  access request; sampled only in IDLE.
- we  input  1  1 = store, 0 = load; captured with req.
- funct3  input  3  RV32 width/sign code; captured with req.
- addr  input  ADDR_W  byte address; captured with req.
- wdata  input  32  store data, right-aligned; captured with req.
- busy  output  1  high whenever state != IDLE.
- ack  output  1  one-cycle response pulse.
- rdata  output  32  load result, valid only while ack = 1, else 0.
- misaligned  output  1  error flag, valid only while ack = 1.

Behaviour:
- Reset (Reset = 0 at an edge): state IDLE; busy = 0, ack = 0, rdata = 0, misaligned = 0; capture registers cleared. RAM contents are not cleared.
- Reset mid-operation: access aborted; a store not yet committed is never written; no ack is issued.
- FSM states: IDLE, WAIT, RESP.
  - IDLE to WAIT when req = 1 and WAIT_STATES > 0; IDLE to RESP when req = 1 and WAIT_STATES = 0.
  - WAIT counts WAIT_STATES cycles, then goes to RESP.
  - RESP always returns to IDLE.
  - req outside IDLE is ignored.
- Latency: ack rises WAIT_STATES + 1 cycles after the req edge; one access per WAIT_STATES + 2 cycles.
- Word index = addr[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
- Byte order: little-endian; lane = addr[1:0].
- Loads (funct3):
  - 000 LB: sign-extend selected byte.
  - 001 LH: sign-extend selected half.
  - 010 LW: full word.
  - 100 LBU: zero-extend byte.
  - 101 LHU: zero-extend half.
- Stores (funct3):
  - 000 SB: wdata[7:0] written to the selected lane.
  - 001 SH: wdata[15:0] written to the selected half.
  - 010 SW: full word.
  - Unaddressed bytes are preserved.
- Store commit happens at the edge entering RESP.
- Misalignment: half access with addr[0] = 1, or word access with addr[1:0] != 0. The access then sets misaligned = 1 in RESP, rdata = 0, and no write occurs.
- Illegal funct3 (011, 110, 111, and stores with 1xx) is treated as misaligned = 1 with no side effects.
- Store ack: rdata = 0.
- Read during RESP sees data including any store just committed.

Optional Feature:
- DATA_MEM_STATS_EN defined: adds outputs load_cnt, store_cnt, err_cnt (32 bits each).
  - Each increments on the ack cycle of the matching outcome; errored accesses bump only err_cnt.
  - Counters cleared by Reset and wrap at 2^32.
- Undefined: no counters and no extra ports.

Decomposition:
- Shared package riscv_mem_pkg holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - FSM state encoding;
  - function for misalignment check.
- One natural sub-module: mem_lane_align. It is purely combinational: load extract/extend and store byte-enable/data replication from funct3 and addr[1:0].

Test Plan:
- WAIT_STATES = 2: SW 0xDEADBEEF to 0x10, then LW 0x10. ack comes 3 cycles after each req; rdata = 0xDEADBEEF; busy high 3 cycles per access.
- After the SW above: SB 0x55 to 0x11, then LW 0x10 gives 0xDEAD55EF. LB 0x13 gives 0xFFFFFFDE; LBU 0x13 gives 0x000000DE; LH 0x12 gives 0xFFFFDEAD.
- LW at 0x0E and SH at 0x11: misaligned = 1, rdata = 0. A subsequent LW 0x10 is unchanged.
- DEPTH_WORDS = 256: SW 0xA5A5A5A5 to 0x400, then LW 0x000 gives 0xA5A5A5A5 (wrap).
- Store in flight (WAIT_STATES = 3), Reset = 0 in the 2nd WAIT cycle: no ack, busy = 0 next cycle, target word unchanged.
- Req held high through ack: a second access starts only on the IDLE cycle after ack; an extra req during WAIT/RESP is ignored.
